// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data memory port between the CPU MEM stage and a debug port
// CPU has fixed priority; a starvation counter force-grants debug after a bounded wait.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CPU, DBG} state_t;

  state_t        state, state_next;
  logic [CW-1:0] starve_cnt;
  logic          dbg_force, cpu_grant, dbg_grant;

  always_comb begin
    dbg_force = dbg_req && (starve_cnt == LIMIT);
    cpu_grant = cpu_req && !dbg_force;
    dbg_grant = dbg_req && !cpu_grant;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_stall = cpu_req && !cpu_grant;

  // Counter only measures an unbroken run of denied debug cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!dbg_req || dbg_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (cpu_grant)      state_next = CPU;
    else if (dbg_grant) state_next = DBG;
  end

  // Read data is steered to whichever requester owned last cycle's access.
  assign cpu_ack   = (state == CPU);
  assign dbg_ack   = (state == DBG);
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign dbg_rdata = dbg_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a reference model
module tb_dmem_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [7:0]  cpu_addr = 0, dbg_addr = 0;
  logic [63:0] cpu_wdata = 0, dbg_wdata = 0;
  logic        cpu_stall, cpu_ack, dbg_ack, mem_en, mem_we;
  logic [63:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous read-first memory the arbiter drives
  logic [63:0] env_mem [256];
  always @(posedge clock) begin
    if (mem_en) begin
      mem_rdata <= env_mem[mem_addr];
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state
  logic [63:0] ref_mem [256];
  int          m_starve;
  int          m_owner;      // 0 none, 1 cpu, 2 dbg
  logic [63:0] m_rdata;
  logic        obs_stall;
  logic        obs_dbg_win;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                       input logic [63:0] c_wd, input logic d_req, input logic d_we,
                       input logic [7:0] d_addr, input logic [63:0] d_wd);
    logic        cg, dg, e_en, e_we;
    logic [7:0]  e_addr;
    logic [63:0] e_wd;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    cg = c_req && !(d_req && m_starve == 4);
    dg = d_req && !cg;
    e_en = cg || dg;
    e_we = cg ? c_we : (dg ? d_we : 1'b0);
    e_addr = cg ? c_addr : (dg ? d_addr : 8'd0);
    e_wd = cg ? c_wd : (dg ? d_wd : 64'd0);
    @(negedge clock);
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("cpu_stall", cpu_stall, c_req && !cg);
    check("cpu_ack", cpu_ack, m_owner == 1);
    check("dbg_ack", dbg_ack, m_owner == 2);
    check("cpu_rdata", cpu_rdata, (m_owner == 1) ? m_rdata : 64'd0);
    check("dbg_rdata", dbg_rdata, (m_owner == 2) ? m_rdata : 64'd0);
    obs_stall = cpu_stall;
    obs_dbg_win = mem_en && !cpu_stall && d_req && (!c_req || cpu_stall) ? 1'b1 : (mem_en && c_req && cpu_stall);
    m_owner = cg ? 1 : (dg ? 2 : 0);
    if (e_en) begin
      m_rdata = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_wd;
    end
    if (d_req && !dg) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
    else              m_starve = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = {$urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    env_mem[20] = 64'd35; ref_mem[20] = 64'd35;
    env_mem[21] = 64'd22; ref_mem[21] = 64'd22;
    env_mem[22] = 64'd6;  ref_mem[22] = 64'd6;
    m_starve = 0; m_owner = 0; m_rdata = 0;

    #3;
    check("reset_cpu_ack", cpu_ack, 1'b0);
    check("reset_dbg_ack", dbg_ack, 1'b0);
    check("reset_cpu_rdata", cpu_rdata, 64'd0);
    check("reset_dbg_rdata", dbg_rdata, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // CPU-only load of address 20
    cycle(1, 0, 8'd20, 64'd0, 0, 0, 8'd0, 64'd0);
    check("load20_no_stall", obs_stall, 1'b0);
    idle();

    // Debug-only store of 6 to address 35
    cycle(0, 0, 8'd0, 64'd0, 1, 1, 8'd35, 64'd6);
    idle();
    check("mem35_written", env_mem[35], 64'd6);

    // Back-to-back CPU loads
    cycle(1, 0, 8'd20, 64'd0, 0, 0, 8'd0, 64'd0);
    cycle(1, 0, 8'd21, 64'd0, 0, 0, 8'd0, 64'd0);
    cycle(1, 0, 8'd22, 64'd0, 0, 0, 8'd0, 64'd0);
    check("b2b_ack3_data", cpu_rdata, 64'd6);
    idle();

    // Continuous contention: debug forced every fifth cycle
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 8'd20, 64'd0, 1, 0, 8'd22, 64'd0);
      check("contend_stall_pattern", obs_stall, (k % 5) == 4);
    end

    // Debug drops its request after three denials, counter restarts
    for (int k = 0; k < 3; k++) cycle(1, 0, 8'd21, 64'd0, 1, 0, 8'd20, 64'd0);
    cycle(1, 0, 8'd21, 64'd0, 0, 0, 8'd0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 8'd21, 64'd0, 1, 0, 8'd20, 64'd0);
      check("restart_stall_pattern", obs_stall, k == 4);
    end

    // Reset during the ack cycle of a CPU load, with starvation built up
    for (int k = 0; k < 3; k++) cycle(1, 0, 8'd21, 64'd0, 1, 0, 8'd20, 64'd0);
    cpu_req = 0; dbg_req = 0;
    check("pre_reset_ack", cpu_ack, 1'b1);
    check("pre_reset_rdata", cpu_rdata, 64'd22);
    reset = 1'b0;
    #1;
    check("async_reset_ack", cpu_ack, 1'b0);
    check("async_reset_rdata", cpu_rdata, 64'd0);
    check("async_reset_dbg_ack", dbg_ack, 1'b0);
    m_owner = 0; m_starve = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 8'd20, 64'd0, 1, 0, 8'd21, 64'd0);
      check("post_reset_stall_pattern", obs_stall, k == 4);
    end

    // Random traffic on a small address window
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 4) != 0, $urandom % 2, 8'($urandom_range(0, 15)), {$urandom, $urandom},
            ($urandom % 2) != 0, $urandom % 2, 8'($urandom_range(0, 15)), {$urandom, $urandom});
    end
    idle();
    idle();
    for (int i = 0; i < 16; i++) check("final_mem", env_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
